// File: rtl/pooled_column_serializer.sv
// Buffers pooled feature-map columns and streams their elements channel-major with coordinates.
// Optional macro SERIALIZER_NEG_ZERO_FLUSH_EN: present fp16 -0 (sign bit only) as +0.
module pooled_column_serializer #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned NUM_CHANNELS = 8,
  parameter int unsigned COL_SIZE     = 5,
  parameter int unsigned NUM_COLS     = 5,
  parameter int unsigned FIFO_DEPTH   = 4,
  localparam int unsigned CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int unsigned ROW_W = (COL_SIZE > 1) ? $clog2(COL_SIZE) : 1,
  localparam int unsigned COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                col_valid_in,
  input  logic [NUM_CHANNELS-1:0][COL_SIZE-1:0][DATA_WIDTH-1:0] col_data_in,
  output logic                                                out_valid,
  input  logic                                                out_ready,
  output logic [DATA_WIDTH-1:0]                               out_data,
  output logic [CH_W-1:0]                                     out_channel,
  output logic [ROW_W-1:0]                                    out_row,
  output logic [COL_W-1:0]                                    out_col,
  output logic                                                out_last,
  output logic                                                overflow
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_STREAM = 1'b1;

  typedef logic [NUM_CHANNELS-1:0][COL_SIZE-1:0][DATA_WIDTH-1:0] col_t;

  col_t             mem [FIFO_DEPTH];
  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [DATA_WIDTH-1:0] raw_data;
  logic full_c;
  logic hs_c;
  logic last_elem_c;
  logic pop_c;
  logic push_c;
  logic drop_c;

  // A full FIFO still accepts a column when the head column leaves on the same edge.
  assign full_c      = (count == CNT_W'(FIFO_DEPTH));
  assign out_valid   = (state == S_STREAM);
  assign hs_c        = out_valid & out_ready;
  assign last_elem_c = (out_channel == CH_W'(NUM_CHANNELS - 1)) &&
                       (out_row == ROW_W'(COL_SIZE - 1));
  assign pop_c       = hs_c & last_elem_c;
  assign push_c      = col_valid_in & (~full_c | pop_c);
  assign drop_c      = col_valid_in & full_c & ~pop_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (push_c) state_nxt = S_STREAM;
      S_STREAM: if (pop_c && (count == CNT_W'(1)) && !push_c) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (drop_c) overflow <= 1'b1;
    end
  end

  // Element index walks rows within a channel, then channels; out_col counts popped columns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_channel <= '0;
      out_row     <= '0;
      out_col     <= '0;
    end else if (hs_c) begin
      if (last_elem_c) begin
        out_channel <= '0;
        out_row     <= '0;
        out_col     <= (out_col == COL_W'(NUM_COLS - 1)) ? '0 : out_col + COL_W'(1);
      end else if (out_row == ROW_W'(COL_SIZE - 1)) begin
        out_row     <= '0;
        out_channel <= out_channel + CH_W'(1);
      end else begin
        out_row     <= out_row + ROW_W'(1);
      end
    end
  end

  // Column storage carries no reset; pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= col_data_in;
  end

  assign raw_data = mem[rd_ptr][out_channel][out_row];

`ifdef SERIALIZER_NEG_ZERO_FLUSH_EN
  assign out_data = (raw_data == {1'b1, {(DATA_WIDTH-1){1'b0}}}) ? '0 : raw_data;
`else
  assign out_data = raw_data;
`endif

  assign out_last = out_valid && last_elem_c && (out_col == COL_W'(NUM_COLS - 1));

endmodule
